// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: default width, bound modes and count direction.
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH_DEFAULT = 8;

  // Values for the SATURATE parameter
  localparam int unsigned CNT_MODE_WRAP = 0;
  localparam int unsigned CNT_MODE_SAT  = 1;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/counter_next_value.sv
// Combinational step function: next count and bound-event flag for one counting edge.
// Kept separate so the cascaded-counter top can reuse the same bound rules.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE  = CNT_MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count_c,
  output logic             bound_hit_c
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
  localparam bit               SAT     = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH:0] count_ext;
  cnt_dir_e       dir;

  assign count_ext = {1'b0, count};
  assign dir       = cnt_dir_e'(up);

  // Step one position in the requested direction; an out-of-range count is treated as the bound
  always_comb begin
    next_count_c = count;
    bound_hit_c  = 1'b0;
    if (dir == CNT_UP) begin
      if (count_ext >= MAX_EXT) begin
        bound_hit_c  = 1'b1;
        next_count_c = SAT ? MAX_W : '0;
      end else begin
        next_count_c = WIDTH'(count_ext + (WIDTH+1)'(1));
      end
    end else begin
      if ((count_ext == '0) || (count_ext > MAX_EXT)) begin
        bound_hit_c  = 1'b1;
        next_count_c = SAT ? '0 : MAX_W;
      end else begin
        next_count_c = WIDTH'(count_ext - (WIDTH+1)'(1));
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised loadable up/down counter with programmable modulus, wrap/saturate mode,
// cascade carry and wrap/overflow status.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE  = CNT_MODE_WRAP
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic             Up,
  input  logic [WIDTH-1:0] Data,
  output logic [WIDTH-1:0] Count,
  output logic             CarryOut,
  output logic             Wrap,
  output logic             Overflow
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);

  // Reject parameter sets that would let the count range escape the register
  if ((WIDTH < 2) || (WIDTH > 63)) begin : g_chk_width
    $fatal(1, "updown_counter_param: WIDTH must be in 2..63");
  end
  if ((MAX_VALUE == 64'd0) || (MAX_VALUE > ((64'd1 << WIDTH) - 64'd1))) begin : g_chk_max
    $fatal(1, "updown_counter_param: MAX_VALUE must be in 1..2**WIDTH-1");
  end
  if (SATURATE > CNT_MODE_SAT) begin : g_chk_mode
    $fatal(1, "updown_counter_param: SATURATE must be 0 or 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] load_value_c;
  logic [WIDTH-1:0] step_value_c;
  logic             bound_hit_c;

  counter_next_value #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE),
    .SATURATE  (SATURATE)
  ) u_next (
    .count        (count_q),
    .up           (Up),
    .next_count_c (step_value_c),
    .bound_hit_c  (bound_hit_c)
  );

  // Parallel load value clamped into the legal count range
  assign load_value_c = ({1'b0, Data} > MAX_EXT) ? MAX_W : Data;

  // Next-state selection: hold, load or count
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    overflow_d = overflow_q;
    if (Enable) begin
      if (Load) begin
        count_d    = load_value_c;
        overflow_d = 1'b0;
      end else begin
        count_d = step_value_c;
        wrap_d  = bound_hit_c;
        if (bound_hit_c) begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
    end
  end

  assign Count    = count_q;
  assign Wrap     = wrap_q;
  assign Overflow = overflow_q;

  // Zero-latency carry so the next stage steps on the same edge this stage wraps
  assign CarryOut = Enable & ~Load & (Up ? (count_q == MAX_W) : (count_q == '0));

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter. It is the successor to the team's fixed 8-bit loadable up counter and keeps that block's Enable/Load/Reset semantics. It adds four things: configurable width, a programmable modulus, up/down direction, and a choice of wrap or saturate at the bounds. It also provides carry-out and wrap/overflow status so instances can be cascaded and monitored by the counter top module.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2)
- MAX_VALUE, 2**WIDTH-1, upper bound of the count range; legal range is 0..MAX_VALUE (1 ≤ MAX_VALUE ≤ 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; clears all state
- Enable  in  1  gates Load and counting; when low, all state holds
- Load  in  1  when Enable=1, Count <= clamp(Data) instead of counting
- Up  in  1  direction: 1 = increment, 0 = decrement
- Data  in  WIDTH  parallel load value, MSB at [WIDTH-1]
- Count  out  WIDTH  registered count
- CarryOut  out  1  combinational; = Enable & ~Load & (Up ? Count==MAX_VALUE : Count==0); drives the Enable of the next cascaded stage
- Wrap  out  1  registered one-cycle pulse; the previous edge crossed a bound (wrapped, or a step was suppressed by saturation)
- Overflow  out  1  registered sticky flag; set with Wrap, cleared only by Reset or a Load

## Operation
Priority at each rising Clock: Reset > ~Enable (hold) > Load > count.
- Reset low (async, any time): Count=0, Wrap=0, Overflow=0 immediately. Registers hold while Reset is low.
- Enable=0: Count and Overflow hold; Wrap <= 0.
- Enable=1, Load=1: Count <= (Data > MAX_VALUE) ? MAX_VALUE : Data; Wrap <= 0; Overflow <= 0. The Up input is ignored.
- Enable=1, Load=0, Up=1:
  - Count < MAX_VALUE: Count+1.
  - Count == MAX_VALUE: Count <= SATURATE ? MAX_VALUE : 0; Wrap <= 1; Overflow <= 1.
- Enable=1, Load=0, Up=0:
  - Count > 0: Count-1.
  - Count == 0: Count <= SATURATE ? 0 : MAX_VALUE; Wrap <= 1; Overflow <= 1.
- Arithmetic: compute in WIDTH+1 bits and compare against MAX_VALUE before writing back. Count never leaves 0..MAX_VALUE, including when MAX_VALUE < 2**WIDTH-1.
- Up may change on any cycle. The new direction applies at the next counting edge, with no dead cycle.
- If Count somehow exceeds MAX_VALUE (unreachable by design): the next counting edge treats it as the bound in the current direction.

## Timing
- Count, Wrap and Overflow update on the Clock rising edge, with 1-cycle latency from Enable/Load/Up/Data.
- CarryOut is combinational from the registered Count and the current Enable/Load/Up, with zero latency. The next stage samples it at the same edge at which this stage wraps.
- Wrap is high for exactly one cycle per bound event. During back-to-back bound events (SATURATE=1 holding at a bound with Enable=1), Wrap stays high on every such cycle.
- Reset deassertion is not synchronised here; the parent synchronises it to Clock. The first counting edge is the first rising Clock with Reset high.
- Reset value of every output: Count=0, Wrap=0, Overflow=0. CarryOut then reads Enable & ~Load & ~Up, because Count==0.

## Structure
- Shared package counter_pkg: localparam defaults (COUNTER_WIDTH_DEFAULT=8), mode constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1 (used for SATURATE), and a direction enum with CNT_DOWN=0 and CNT_UP=1.
- Single module. An optional combinational helper, counter_next_value, computes {next_count, bound_hit} from (count, up, MAX_VALUE, SATURATE) so that it can be reused by the planned cascaded-counter top. All registers stay in updown_counter_param.
- Elaboration-time checks: fatal if MAX_VALUE is 0 or exceeds 2**WIDTH-1.

## Test plan
- Reset/default: WIDTH=8, Reset low mid-count at Count=0x37 -> Count, Wrap and Overflow go to 0 without waiting for a clock edge. Release, then apply Enable=1, Up=1 for 3 cycles -> Count=3.
- Up-wrap with modulus: WIDTH=8, MAX_VALUE=9, SATURATE=0; Load 8, then Up=1 for 3 cycles -> Count 9, 0, 1. CarryOut is high while Count=9. Wrap pulses once, on the cycle after 9->0. Overflow stays 1 until the next Load.
- Down-saturate: SATURATE=1, MAX_VALUE=9; Load 1, then Up=0 for 3 cycles -> Count 0, 0, 0. Wrap is high on the 2nd and 3rd cycles.
- Load clamp and priority: MAX_VALUE=9; Enable=1, Load=1, Data=0xC8 -> Count=9, Overflow cleared. Enable=0, Load=1, Data=5 -> Count holds at 9.
- Direction change: Load 4, then Up=1,1,0,0,0 -> Count 5, 6, 5, 4, 3, with no dead cycle and Wrap=0 throughout.
- Cascade: two WIDTH=4 instances, with stage-1 Enable = stage-0 CarryOut; count up 300 cycles from 0 -> combined {stage1, stage0} = 300 mod 256 = 44 (0x2C).
